wb_write_arbiter: RTL and testbench
===================================

// Module: wb_write_arbiter
// PURPOSE
//  Sole writer of the 32x32 register file write port (we/waddr/wdata). Merges the
//  in-order pipeline writeback (primary, no backpressure) with a long-latency
//  producer (secondary, e.g. divider or load return; valid/ready) through a small FIFO.
//  Squashes queued writes made stale by newer primary writes, and reports pending
//  queued destinations so the decode stage can stall on them.
// PARAMETERS
//  DEPTH  4   secondary FIFO entries, power of two, >=2
//  AW     5   register address width
//  DW     32  register data width
// PORTS
//  clk        in   1       clock, all state on rising edge
//  resetn     in   1       asynchronous reset, active low
//  p_we       in   1       primary write request, always accepted
//  p_waddr    in   AW      primary destination register
//  p_wdata    in   DW      primary write data
//  s_valid    in   1       secondary write request valid
//  s_ready    out  1       secondary request accepted this cycle when s_valid=1
//  s_waddr    in   AW      secondary destination register
//  s_wdata    in   DW      secondary write data
//  rf_we      out  1       register file write enable (registered)
//  rf_waddr   out  AW      register file write address (registered)
//  rf_wdata   out  DW      register file write data (registered)
//  q_raddr1   in   AW      decode read address 1 to check
//  q_raddr2   in   AW      decode read address 2 to check
//  q_hit1     out  1       valid FIFO entry targets q_raddr1 (0 when q_raddr1=0)
//  q_hit2     out  1       valid FIFO entry targets q_raddr2 (0 when q_raddr2=0)
//  q_count    out  clog2(DEPTH)+1  FIFO occupancy incl. squashed entries
// BEHAVIOUR
//  Reset: rf_we=0, rf_waddr=0, rf_wdata=0, q_count=0, all entry valid bits=0,
//   head/tail=0; s_ready=0 while resetn=0. Reset mid-operation discards queued writes.
//  s_ready = resetn_sync_state & (q_count<DEPTH), from registers only; no same-cycle
//   pop-to-push passthrough, so a full FIFO stalls secondary for >=1 cycle.
//  Push: s_valid&s_ready -> entry{valid,addr,data} at tail. Push with s_waddr=0 or
//   s_waddr==p_waddr with p_we=1 (same-cycle primary counts as newer) is accepted
//   but not enqueued.
//  Squash: p_we=1 & p_waddr!=0 clears valid of every queued entry with that addr
//   in the same edge; entries stay allocated until popped.
//  Port selection each cycle (result appears on rf_* after the next edge, latency 1):
//   1) p_we=1 & p_waddr!=0 -> rf_we<=1, primary addr/data; FIFO holds.
//   2) else if q_count>0 -> pop head; rf_we<=head.valid, addr/data from head.
//   3) else rf_we<=0; rf_waddr/rf_wdata hold previous values.
//   p_we=1 with p_waddr=0 never writes and does not block a pop.
//  Secondary latency with idle primary and empty FIFO: push edge, pop edge -> rf_we
//   high 2 cycles after acceptance. Primary starvation of the FIFO is allowed.
//  Simultaneous push and pop in one cycle: both occur, q_count unchanged.
//  Pointers wrap modulo DEPTH; q_count in 0..DEPTH, never exceeds DEPTH.
//  q_hit1/2 combinational over valid entries only; squashed entries never hit.
//   Stall decisions by decode use q_hit; a squash lowers q_hit the next cycle.
// TESTING
//  1 reset: resetn=0 with FIFO holding 3 entries -> next cycle q_count=0, rf_we=0,
//    q_hit1=0 for all addresses; after release s_ready=1.
//  2 primary only: p_we=1,p_waddr=7,p_wdata=0xDEADBEEF -> next cycle rf_we=1,
//    rf_waddr=7, rf_wdata=0xDEADBEEF; p_waddr=0 -> rf_we=0.
//  3 secondary idle path: s_valid=1,s_waddr=9,s_wdata=0x12345678 at cycle N ->
//    q_hit on 9 from N+1, rf_we=1/rf_waddr=9 at N+2, q_count back to 0.
//  4 full/backpressure: primary held busy, push 4 entries (addr 1..4) -> q_count=4,
//    s_ready=0, 5th request held; release primary -> pops in order 1,2,3,4, 5th accepted.
//  5 squash: queue addr 10 data 0xA; primary writes r10=0xB -> q_hit on 10 drops; pop
//    yields rf_we=0; regfile model ends with r10=0xB.
//  6 same-cycle conflict: s_valid with s_waddr=3 and p_we with p_waddr=3 -> s_ready=1,
//    nothing enqueued, q_count unchanged, only primary data written.

Source files
------------

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter
//   Sole writer of the register file write port. Merges the in-order pipeline
//   writeback (primary, always accepted, highest priority) with a long-latency
//   producer (secondary, valid/ready) buffered in a small circular FIFO.
//   Queued writes whose destination is overwritten by a newer primary write are
//   squashed (valid cleared) but stay allocated until popped, so occupancy and
//   pop order are unaffected. Decode can query pending destinations via q_hit*.
//
// Ports
//   clk, resetn                 clock (rising edge), async active-low reset
//   p_we, p_waddr, p_wdata      primary writeback, no backpressure
//   s_valid, s_ready            secondary handshake
//   s_waddr, s_wdata            secondary destination / data
//   rf_we, rf_waddr, rf_wdata   registered register file write port
//   q_raddr1, q_raddr2          decode source registers to check
//   q_hit1, q_hit2              a live queued write targets that register
//   q_count                     FIFO occupancy including squashed entries
module wb_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     p_we,
  input  logic [AW-1:0]            p_waddr,
  input  logic [DW-1:0]            p_wdata,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [AW-1:0]            s_waddr,
  input  logic [DW-1:0]            s_wdata,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_waddr,
  output logic [DW-1:0]            rf_wdata,
  input  logic [AW-1:0]            q_raddr1,
  input  logic [AW-1:0]            q_raddr2,
  output logic                     q_hit1,
  output logic                     q_hit2,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic             ready_en;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [DEPTH-1:0] e_valid;
  logic [AW-1:0]    e_addr [DEPTH];
  logic [DW-1:0]    e_data [DEPTH];

  logic prim_wr;
  logic push;
  logic enq;
  logic pop;

  // Writes to register 0 are architecturally discarded, so they neither
  // occupy the port nor block the FIFO.
  assign prim_wr = p_we & (p_waddr != '0);

  // Ready is derived from registers only. ready_en comes up one edge after
  // reset release, so the FIFO never accepts during or straight out of reset.
  assign s_ready = ready_en & (q_count < DEPTH_C);

  assign push = s_valid & s_ready;

  // An accepted request that is already stale (r0, or overwritten by the
  // primary in the same cycle) completes the handshake without taking a slot.
  assign enq  = push & (s_waddr != '0) & ~(prim_wr & (s_waddr == p_waddr));

  assign pop  = ~prim_wr & (q_count != '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_en <= 1'b0;
      head     <= '0;
      tail     <= '0;
      q_count  <= '0;
      e_valid  <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_addr[i] <= '0;
        e_data[i] <= '0;
      end
    end else begin
      ready_en <= 1'b1;

      // Squash: a newer primary write makes any queued write to the same
      // register obsolete. Slots stay allocated and drain as no-op pops.
      if (prim_wr) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (e_addr[i] == p_waddr) begin
            e_valid[i] <= 1'b0;
          end
        end
      end

      if (pop) begin
        e_valid[head] <= 1'b0;
        head          <= head + PTR_ONE;
      end

      // Push and pop never target the same slot: pop needs a non-empty FIFO
      // and push needs a non-full one. The enqueued address never equals an
      // active primary address, so the squash above cannot hit this slot's
      // new contents.
      if (enq) begin
        e_valid[tail] <= 1'b1;
        e_addr[tail]  <= s_waddr;
        e_data[tail]  <= s_wdata;
        tail          <= tail + PTR_ONE;
      end

      q_count <= q_count + CW'(enq) - CW'(pop);

      if (prim_wr) begin
        rf_we    <= 1'b1;
        rf_waddr <= p_waddr;
        rf_wdata <= p_wdata;
      end else if (pop) begin
        // A squashed head still pops, but produces no write.
        rf_we    <= e_valid[head];
        rf_waddr <= e_addr[head];
        rf_wdata <= e_data[head];
      end else begin
        rf_we    <= 1'b0;
      end
    end
  end

  // Pending-destination lookup over live entries only; r0 never hits.
  always_comb begin
    q_hit1 = 1'b0;
    q_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (e_valid[i] && (e_addr[i] == q_raddr1)) q_hit1 = 1'b1;
      if (e_valid[i] && (e_addr[i] == q_raddr2)) q_hit2 = 1'b1;
    end
    if (q_raddr1 == '0) q_hit1 = 1'b0;
    if (q_raddr2 == '0) q_hit2 = 1'b0;
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          p_we = 1'b0;
  logic [AW-1:0] p_waddr = '0;
  logic [DW-1:0] p_wdata = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [AW-1:0] s_waddr = '0;
  logic [DW-1:0] s_wdata = '0;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] q_raddr1 = '0;
  logic [AW-1:0] q_raddr2 = '0;
  logic          q_hit1;
  logic          q_hit2;
  logic [2:0]    q_count;

  wb_write_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .resetn(resetn),
    .p_we(p_we), .p_waddr(p_waddr), .p_wdata(p_wdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_waddr(s_waddr), .s_wdata(s_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q_raddr1(q_raddr1), .q_raddr2(q_raddr2),
    .q_hit1(q_hit1), .q_hit2(q_hit2), .q_count(q_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Register file as seen by a consumer of the write port.
  logic [DW-1:0] tb_rf [32];
  always @(posedge clk) begin
    if (rf_we) tb_rf[rf_waddr] <= rf_wdata;
  end

  task automatic drive(input logic pw, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                       input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd);
    p_we = pw; p_waddr = pa; p_wdata = pd;
    s_valid = sv; s_waddr = sa; s_wdata = sd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model: queue of pending writes ----------------
  typedef struct {
    logic          v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  logic          m_ready;
  logic          m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;

  task automatic model_reset();
    mq.delete();
    m_ready = 1'b0;
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  function automatic logic m_hit(input logic [AW-1:0] a);
    logic h;
    h = 1'b0;
    foreach (mq[i]) if (mq[i].v && mq[i].a == a && a != 0) h = 1'b1;
    return h;
  endfunction

  task automatic model_edge(input logic exp_ready);
    logic prim;
    ent_t e;
    prim = p_we && (p_waddr != 0);
    if (prim) begin
      m_we = 1'b1; m_waddr = p_waddr; m_wdata = p_wdata;
      foreach (mq[i]) if (mq[i].a == p_waddr) mq[i].v = 1'b0;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_we = e.v; m_waddr = e.a; m_wdata = e.d;
    end else begin
      m_we = 1'b0;
    end
    if (s_valid && exp_ready && s_waddr != 0 && !(prim && s_waddr == p_waddr)) begin
      e.v = 1'b1; e.a = s_waddr; e.d = s_wdata;
      mq.push_back(e);
    end
    m_ready = 1'b1;
  endtask

  task automatic rstep();
    logic er;
    drive($urandom_range(0, 99) < 35, AW'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 99) < 60, AW'($urandom_range(0, 7)), $urandom);
    q_raddr1 = AW'($urandom_range(0, 7));
    q_raddr2 = AW'($urandom_range(0, 7));
    #3;
    er = m_ready && (mq.size() < DEPTH);
    chk("rnd_s_ready", s_ready, er);
    chk("rnd_q_count", q_count, mq.size());
    chk("rnd_q_hit1", q_hit1, m_hit(q_raddr1));
    chk("rnd_q_hit2", q_hit2, m_hit(q_raddr2));
    @(posedge clk);
    #1;
    model_edge(er);
    chk("rnd_rf_we", rf_we, m_we);
    chk("rnd_rf_waddr", rf_waddr, m_waddr);
    chk("rnd_rf_wdata", rf_wdata, m_wdata);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          p_we;
    logic [AW-1:0] p_waddr;
    logic [DW-1:0] p_wdata;
    logic          s_valid;
    logic [AW-1:0] s_waddr;
    logic [DW-1:0] s_wdata;
    logic [AW-1:0] raddr;
    logic          e_we;
    logic [AW-1:0] e_waddr;
    logic [DW-1:0] e_wdata;
    logic [2:0]    e_count;
    logic          e_hit;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic anyhit;

    vt[0] = '{1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        5'd0, 1'b1, 5'd7, 32'hDEADBEEF, 3'd0, 1'b0};
    vt[1] = '{1'b1, 5'd0, 32'h11111111, 1'b0, 5'd0, 32'h0,        5'd0, 1'b0, 5'd7, 32'hDEADBEEF, 3'd0, 1'b0};
    vt[2] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h12345678, 5'd9, 1'b0, 5'd7, 32'hDEADBEEF, 3'd1, 1'b1};
    vt[3] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd9, 1'b1, 5'd9, 32'h12345678, 3'd0, 1'b0};
    vt[4] = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd3, 32'h44,       5'd3, 1'b1, 5'd3, 32'h33,       3'd0, 1'b0};
    vt[5] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h55,       5'd0, 1'b0, 5'd3, 32'h33,       3'd0, 1'b0};
    vt[6] = '{1'b1, 5'd0, 32'h77,       1'b1, 5'd5, 32'h66,       5'd5, 1'b0, 5'd3, 32'h33,       3'd1, 1'b1};
    vt[7] = '{1'b1, 5'd0, 32'h88,       1'b0, 5'd0, 32'h0,        5'd5, 1'b1, 5'd5, 32'h66,       3'd0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_q_count", q_count, 0);
    chk("rst_s_ready", s_ready, 0);
    resetn = 1'b1;
    tick();
    chk("rel_s_ready", s_ready, 1);

    // Primary-only, secondary idle path, same-cycle conflict, r0 corner cases.
    for (int k = 0; k < 8; k++) begin
      drive(vt[k].p_we, vt[k].p_waddr, vt[k].p_wdata, vt[k].s_valid, vt[k].s_waddr, vt[k].s_wdata);
      q_raddr1 = vt[k].raddr;
      tick();
      chk($sformatf("vec%0d_rf_we", k), rf_we, vt[k].e_we);
      chk($sformatf("vec%0d_rf_waddr", k), rf_waddr, vt[k].e_waddr);
      chk($sformatf("vec%0d_rf_wdata", k), rf_wdata, vt[k].e_wdata);
      chk($sformatf("vec%0d_q_count", k), q_count, vt[k].e_count);
      chk($sformatf("vec%0d_q_hit1", k), q_hit1, vt[k].e_hit);
    end

    // Full FIFO under a busy primary, then in-order drain.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'd20, 32'hF0, 1'b1, AW'(i), 32'h100 + i);
      #3;
      chk("full_fill_ready", s_ready, 1);
      tick();
    end
    chk("full_q_count", q_count, 4);
    chk("full_s_ready", s_ready, 0);
    drive(1'b1, 5'd20, 32'hF0, 1'b1, 5'd5, 32'h105);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("full_hold_count", q_count, 4);
      chk("full_hold_ready", s_ready, 0);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h105);
    #3;
    chk("drain_ready_full", s_ready, 0);
    tick();
    chk("drain1_we", rf_we, 1);
    chk("drain1_addr", rf_waddr, 1);
    chk("drain1_data", rf_wdata, 32'h101);
    chk("drain1_count", q_count, 3);
    #3;
    chk("drain_ready_free", s_ready, 1);
    tick();
    chk("drain2_addr", rf_waddr, 2);
    chk("drain2_count", q_count, 3);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    for (int i = 3; i <= 5; i++) begin
      tick();
      chk($sformatf("drain%0d_we", i), rf_we, 1);
      chk($sformatf("drain%0d_addr", i), rf_waddr, i);
      chk($sformatf("drain%0d_data", i), rf_wdata, 32'h100 + i);
      chk($sformatf("drain%0d_count", i), q_count, 5 - i);
    end

    // Squash: queued r10 overwritten by a newer primary write.
    drive(1'b1, 5'd20, 32'hF1, 1'b1, 5'd10, 32'hA);
    q_raddr1 = 5'd10;
    tick();
    chk("sq_count", q_count, 1);
    chk("sq_hit_before", q_hit1, 1);
    drive(1'b1, 5'd10, 32'hB, 1'b0, 5'd0, 32'h0);
    #3;
    chk("sq_hit_same_cycle", q_hit1, 1);
    tick();
    chk("sq_prim_we", rf_we, 1);
    chk("sq_prim_addr", rf_waddr, 10);
    chk("sq_prim_data", rf_wdata, 32'hB);
    chk("sq_hit_after", q_hit1, 0);
    chk("sq_count_kept", q_count, 1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    chk("sq_pop_we", rf_we, 0);
    chk("sq_pop_count", q_count, 0);
    tick();
    chk("sq_rf10", tb_rf[10], 32'hB);

    // Reset with three queued entries.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd20, 32'hF2, 1'b1, AW'(11 + i), 32'h200 + i);
      tick();
    end
    chk("rst3_count_before", q_count, 3);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    resetn = 1'b0;
    #1;
    chk("rst3_count", q_count, 0);
    chk("rst3_rf_we", rf_we, 0);
    chk("rst3_s_ready", s_ready, 0);
    anyhit = 1'b0;
    for (int a = 0; a < 32; a++) begin
      q_raddr1 = AW'(a);
      #1;
      anyhit |= q_hit1;
    end
    chk("rst3_no_hit", anyhit, 0);
    tick();
    resetn = 1'b1;
    tick();
    chk("rst3_ready_after", s_ready, 1);
    chk("rst3_count_after", q_count, 0);

    // Randomized run against the queue model.
    resetn = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    model_reset();
    tick();
    resetn = 1'b1;
    for (int n = 0; n < 3000; n++) rstep();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
